// File: rtl/calendar_counter.sv
// Calendar counter: tracks month/day/day-of-year/year, advances one day per
// prescaler period or per step pulse (forward or backward), and converts a
// loaded day-of-year into month/day over one cycle per month.
module calendar_counter #(
  parameter int DIV       = 10_000_000,
  parameter int YEAR_W    = 12,
  parameter int YEAR_INIT = 2000
) (
  input  logic              ADC_CLK_10,
  input  logic              rst_n,
  input  logic              run_en,
  input  logic              dir,
  input  logic              step,
  input  logic              leap_force,
  input  logic              load,
  input  logic [8:0]        load_doy,
  input  logic [YEAR_W-1:0] load_year,
  output logic [3:0]        month,
  output logic [4:0]        day,
  output logic [8:0]        doy,
  output logic [YEAR_W-1:0] year,
  output logic              leap,
  output logic              busy,
  output logic              tick,
  output logic              year_roll
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic {RUN = 1'b0, CONV = 1'b1} state_t;

  state_t            state;
  logic [PW-1:0]     presc;
  logic [3:0]        conv_m;
  logic [8:0]        conv_r;

  logic [8:0]        year_len;
  logic              new_leap;
  logic [8:0]        new_year_len;
  logic [YEAR_W-1:0] prev_year;
  logic              prev_leap;
  logic [8:0]        prev_year_len;
  logic [3:0]        prev_month;
  logic [4:0]        cur_month_len;
  logic [4:0]        prev_month_len;
  logic [4:0]        conv_month_len;
  logic [8:0]        load_doy_clamped;

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
    case (m)
      4'd2:                      month_len = lp ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   month_len = 5'd30;
      default:                   month_len = 5'd31;
    endcase
  endfunction

  assign leap           = (year[1:0] == 2'b00) | leap_force;
  assign year_len       = leap ? 9'd366 : 9'd365;
  assign new_leap       = (load_year[1:0] == 2'b00) | leap_force;
  assign new_year_len   = new_leap ? 9'd366 : 9'd365;
  assign prev_year      = year - YEAR_W'(1);
  assign prev_leap      = (prev_year[1:0] == 2'b00) | leap_force;
  assign prev_year_len  = prev_leap ? 9'd366 : 9'd365;
  assign prev_month     = (month == 4'd1) ? 4'd12 : month - 4'd1;
  assign cur_month_len  = month_len(month, leap);
  assign prev_month_len = month_len(prev_month, leap);
  assign conv_month_len = month_len(conv_m, leap);

  // Clamp the requested day-of-year into 1..year_len of the year being loaded.
  always_comb begin
    load_doy_clamped = load_doy;
    if (load_doy == 9'd0) begin
      load_doy_clamped = 9'd1;
    end else if (load_doy > new_year_len) begin
      load_doy_clamped = new_year_len;
    end
  end

  // Prescaler, load/convert FSM and single-day advance; load beats conversion beats advance.
  always_ff @(posedge ADC_CLK_10 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      presc     <= '0;
      tick      <= 1'b0;
      year_roll <= 1'b0;
      busy      <= 1'b0;
      month     <= 4'd1;
      day       <= 5'd1;
      doy       <= 9'd1;
      year      <= YEAR_W'(YEAR_INIT);
      conv_m    <= 4'd1;
      conv_r    <= 9'd1;
    end else begin
      tick      <= 1'b0;
      year_roll <= 1'b0;

      if (state == CONV) begin
        presc <= '0;
      end else if (run_en) begin
        if (presc == PRESC_LAST) begin
          presc <= '0;
          tick  <= 1'b1;
        end else begin
          presc <= presc + PW'(1);
        end
      end

      if (load) begin
        year   <= load_year;
        doy    <= load_doy_clamped;
        conv_m <= 4'd1;
        conv_r <= load_doy_clamped;
        busy   <= 1'b1;
        state  <= CONV;
      end else if (state == CONV) begin
        if (conv_r > {4'd0, conv_month_len}) begin
          conv_r <= conv_r - {4'd0, conv_month_len};
          conv_m <= conv_m + 4'd1;
        end else begin
          month <= conv_m;
          day   <= conv_r[4:0];
          busy  <= 1'b0;
          state <= RUN;
        end
      end else if (tick | step) begin
        if (!dir) begin
          if (doy >= year_len) begin
            doy       <= 9'd1;
            month     <= 4'd1;
            day       <= 5'd1;
            year      <= year + YEAR_W'(1);
            year_roll <= 1'b1;
          end else begin
            doy <= doy + 9'd1;
            if (day == cur_month_len) begin
              day   <= 5'd1;
              month <= month + 4'd1;
            end else begin
              day <= day + 5'd1;
            end
          end
        end else begin
          if (doy == 9'd1) begin
            year      <= prev_year;
            month     <= 4'd12;
            day       <= 5'd31;
            doy       <= prev_year_len;
            year_roll <= 1'b1;
          end else begin
            doy <= doy - 9'd1;
            if (day == 5'd1) begin
              month <= prev_month;
              day   <= prev_month_len;
            end else begin
              day <= day - 5'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_calendar_counter.sv
// Testbench for calendar_counter: directed calendar scenarios plus randomized
// traffic, all checked every cycle against a date-arithmetic reference model.
module tb_calendar_counter;

  localparam int DIV       = 4;
  localparam int YEAR_W    = 12;
  localparam int YEAR_INIT = 2000;
  localparam int YMOD      = 1 << YEAR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              run_en;
  logic              dir;
  logic              step;
  logic              leap_force;
  logic              load;
  logic [8:0]        load_doy;
  logic [YEAR_W-1:0] load_year;
  logic [3:0]        month;
  logic [4:0]        day;
  logic [8:0]        doy;
  logic [YEAR_W-1:0] year;
  logic              leap;
  logic              busy;
  logic              tick;
  logic              year_roll;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int month;
    int day;
    int doy;
    int year;
    int cnt;
    int busy;
    int pm;
    int pd;
    bit tick;
    bit roll;
  } model_t;

  model_t m;

  calendar_counter #(
    .DIV(DIV),
    .YEAR_W(YEAR_W),
    .YEAR_INIT(YEAR_INIT)
  ) dut (
    .ADC_CLK_10(clk),
    .rst_n(rst_n),
    .run_en(run_en),
    .dir(dir),
    .step(step),
    .leap_force(leap_force),
    .load(load),
    .load_doy(load_doy),
    .load_year(load_year),
    .month(month),
    .day(day),
    .doy(doy),
    .year(year),
    .leap(leap),
    .busy(busy),
    .tick(tick),
    .year_roll(year_roll)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  function automatic bit is_leap(input int y);
    return ((y % 4) == 0) || (leap_force == 1'b1);
  endfunction

  // Calendar date of a day-of-year using cumulative month-end tables.
  function automatic void date_of(input int d, input bit lp, output int mo, output int dy);
    int ends[13] = '{0, 31, 59, 90, 120, 151, 181, 212, 243, 273, 304, 334, 365};
    bit found = 1'b0;
    mo = 12;
    dy = 31;
    for (int k = 1; k <= 12; k++) begin
      int hi;
      int lo;
      hi = ends[k] + ((lp && k >= 2) ? 1 : 0);
      lo = ends[k-1] + ((lp && (k - 1) >= 2) ? 1 : 0);
      if (!found && d <= hi) begin
        found = 1'b1;
        mo = k;
        dy = d - lo;
      end
    end
  endfunction

  function automatic model_t next_model(input model_t s);
    model_t n;
    int     d;
    int     ylen;
    int     mo;
    int     dy;
    bit     lp;
    n = s;
    n.tick = 1'b0;
    n.roll = 1'b0;
    if (s.busy != 0) begin
      n.cnt = 0;
    end else if (run_en) begin
      if (s.cnt == DIV - 1) begin
        n.cnt  = 0;
        n.tick = 1'b1;
      end else begin
        n.cnt = s.cnt + 1;
      end
    end
    lp = is_leap(s.year);
    ylen = lp ? 366 : 365;
    if (load) begin
      n.year = int'(load_year);
      d = int'(load_doy);
      if (d == 0) d = 1;
      if (d > (is_leap(n.year) ? 366 : 365)) d = is_leap(n.year) ? 366 : 365;
      n.doy = d;
      date_of(d, is_leap(n.year), mo, dy);
      n.busy = mo;
      n.pm = mo;
      n.pd = dy;
    end else if (s.busy != 0) begin
      n.busy = s.busy - 1;
      if (n.busy == 0) begin
        n.month = s.pm;
        n.day   = s.pd;
      end
    end else if (s.tick || step) begin
      if (!dir) begin
        if (s.doy >= ylen) begin
          n.doy = 1;
          n.month = 1;
          n.day = 1;
          n.year = (s.year + 1) % YMOD;
          n.roll = 1'b1;
        end else begin
          n.doy = s.doy + 1;
          date_of(n.doy, lp, mo, dy);
          n.month = mo;
          n.day = dy;
        end
      end else begin
        if (s.doy == 1) begin
          n.year = (s.year + YMOD - 1) % YMOD;
          n.doy = is_leap(n.year) ? 366 : 365;
          n.month = 12;
          n.day = 31;
          n.roll = 1'b1;
        end else begin
          n.doy = s.doy - 1;
          date_of(n.doy, lp, mo, dy);
          n.month = mo;
          n.day = dy;
        end
      end
    end
    return n;
  endfunction

  // Reference model advances on the same edges as the design, reset asynchronously.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '{month: 1, day: 1, doy: 1, year: YEAR_INIT, cnt: 0, busy: 0,
             pm: 1, pd: 1, tick: 1'b0, roll: 1'b0};
    end else begin
      m <= next_model(m);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every falling edge, all outputs are compared against the model.
  always @(negedge clk) begin
    checkOutput("month", int'(month), m.month);
    checkOutput("day", int'(day), m.day);
    checkOutput("doy", int'(doy), m.doy);
    checkOutput("year", int'(year), m.year);
    checkOutput("leap", int'(leap), is_leap(m.year) ? 1 : 0);
    checkOutput("busy", int'(busy), (m.busy != 0) ? 1 : 0);
    checkOutput("tick", int'(tick), int'(m.tick));
    checkOutput("year_roll", int'(year_roll), int'(m.roll));
  end

  task automatic applyStimulus(input logic l, input int ld, input int ly, input logic s, input logic d);
    @(posedge clk);
    #1;
    load      = l;
    load_doy  = 9'(ld);
    load_year = YEAR_W'(ly);
    step      = s;
    dir       = d;
    @(posedge clk);
    #1;
    load = 1'b0;
    step = 1'b0;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    checkOutput("busy_bound", int'(busy), 0);
  endtask

  task automatic checkDate(input string tag, input int mo, input int dy, input int dd, input int yy);
    checkOutput({tag, "_month"}, int'(month), mo);
    checkOutput({tag, "_day"}, int'(day), dy);
    checkOutput({tag, "_doy"}, int'(doy), dd);
    checkOutput({tag, "_year"}, int'(year), yy);
  endtask

  initial begin
    int n;
    int ticks;
    int first_t;
    int last_t;
    int cyc;
    int ly;
    int ld;

    rst_n = 1'b0;
    run_en = 1'b0;
    dir = 1'b0;
    step = 1'b0;
    leap_force = 1'b0;
    load = 1'b0;
    load_doy = '0;
    load_year = '0;

    #12;
    checkDate("reset", 1, 1, 1, 2000);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_tick", int'(tick), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_en = 1'b1;

    // Free-running ticks from 1/1.
    ticks = 0;
    first_t = 0;
    last_t = 0;
    cyc = 0;
    while (ticks < 31 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (tick) begin
        ticks++;
        if (ticks == 1) first_t = cyc;
        last_t = cyc;
      end
    end
    checkOutput("tick_count", ticks, 31);
    checkOutput("tick_span", last_t - first_t, 120);
    @(posedge clk);
    #1;
    run_en = 1'b0;
    checkDate("after31", 2, 1, 32, 2000);
    ticks = 0;
    repeat (20) begin
      @(negedge clk);
      if (tick) ticks++;
    end
    checkOutput("frozen_ticks", ticks, 0);
    checkOutput("frozen_doy", int'(doy), 32);
    @(posedge clk);
    #1;
    run_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 10);
    checkOutput("resume_tick_delay", n, 4);
    @(posedge clk);
    #1;
    run_en = 1'b0;

    // Loads and conversion latency.
    applyStimulus(1'b1, 60, 2001, 1'b0, 1'b0);
    waitIdle(n);
    checkOutput("busy_60_2001", n, 3);
    checkDate("d60_2001", 3, 1, 60, 2001);
    applyStimulus(1'b1, 60, 2000, 1'b0, 1'b0);
    waitIdle(n);
    checkOutput("busy_60_2000", n, 2);
    checkDate("d60_2000", 2, 29, 60, 2000);

    // Forward year wrap.
    applyStimulus(1'b1, 365, 2023, 1'b0, 1'b0);
    waitIdle(n);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    checkDate("fwd_wrap", 1, 1, 1, 2024);
    checkOutput("fwd_roll", int'(year_roll), 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("fwd_roll_end", int'(year_roll), 0);

    // Backward year wrap.
    applyStimulus(1'b1, 1, 2024, 1'b0, 1'b0);
    waitIdle(n);
    checkOutput("busy_1_2024", n, 1);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
    checkDate("bwd_wrap", 12, 31, 365, 2023);
    checkOutput("bwd_roll", int'(year_roll), 1);

    // Clamping and step during conversion.
    applyStimulus(1'b1, 0, 2023, 1'b0, 1'b0);
    waitIdle(n);
    checkDate("clamp_lo", 1, 1, 1, 2023);
    applyStimulus(1'b1, 400, 2023, 1'b0, 1'b0);
    checkOutput("clamp_hi_doy", int'(doy), 365);
    waitIdle(n);
    checkOutput("busy_400", n, 12);
    checkDate("clamp_hi", 12, 31, 365, 2023);
    applyStimulus(1'b1, 400, 2023, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    waitIdle(n);
    checkDate("step_in_busy", 12, 31, 365, 2023);

    // Load during conversion restarts it.
    applyStimulus(1'b1, 300, 2023, 1'b0, 1'b0);
    applyStimulus(1'b1, 32, 2023, 1'b0, 1'b0);
    waitIdle(n);
    checkOutput("busy_restart", n, 2);
    checkDate("restart", 2, 1, 32, 2023);

    // Reset in the middle of a conversion.
    applyStimulus(1'b1, 200, 2023, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checkDate("mid_reset", 1, 1, 1, 2000);
    checkOutput("mid_reset_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Forced leap year, then dropping the force on day 366.
    @(posedge clk);
    #1;
    leap_force = 1'b1;
    applyStimulus(1'b1, 366, 2023, 1'b0, 1'b0);
    waitIdle(n);
    checkOutput("busy_366_forced", n, 12);
    checkDate("forced366", 12, 31, 366, 2023);
    checkOutput("forced_leap", int'(leap), 1);
    @(posedge clk);
    #1;
    leap_force = 1'b0;
    #1;
    checkOutput("unforced_leap", int'(leap), 0);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    checkDate("drop_force_wrap", 1, 1, 1, 2024);
    checkOutput("drop_force_roll", int'(year_roll), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      run_en = ($urandom_range(0, 7) != 0);
      dir    = $urandom_range(0, 1) == 1;
      step   = ($urandom_range(0, 3) == 0);
      load   = ($urandom_range(0, 29) == 0);
      if (load) begin
        case ($urandom_range(0, 5))
          0:       ly = 0;
          1:       ly = YMOD - 1;
          2:       ly = 2023;
          3:       ly = 2024;
          default: ly = int'($urandom_range(0, YMOD - 1));
        endcase
        case ($urandom_range(0, 7))
          0:       ld = 0;
          1:       ld = 1;
          2:       ld = 60;
          3:       ld = 365;
          4:       ld = 366;
          default: ld = int'($urandom_range(0, 511));
        endcase
        load_year  = YEAR_W'(ly);
        load_doy   = 9'(ld);
        leap_force = ($urandom_range(0, 3) == 0);
      end
    end

    @(posedge clk);
    #1;
    load = 1'b0;
    step = 1'b0;
    run_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/calendar_counter.md
CALENDAR_COUNTER -- requirements
Module: calendar_counter

Interface
REQ-001 SHALL have parameter DIV, 10_000_000, ADC_CLK_10 cycles per automatic day advance (1 Hz at 10 MHz); legal range 2..2^24.
REQ-002 SHALL have parameter YEAR_W, 12, year counter width in bits.
REQ-003 SHALL have parameter YEAR_INIT, 2000, year value loaded at reset.
REQ-004 SHALL have port ADC_CLK_10  in  1  sole clock; all state rising-edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports run_en (in, 1: enable prescaled advance), dir (in, 1: 0 = forward, 1 = backward), step (in, 1: single-cycle pulse, one-day advance) and leap_force (in, 1: treat the current year as leap).
REQ-007 SHALL have ports load (in, 1: single-cycle pulse starting a date load), load_doy (in, 9: day-of-year to load) and load_year (in, YEAR_W: year to load).
REQ-008 SHALL have ports month (out, 4: 1..12), day (out, 5: 1..31), doy (out, 9: 1..366), year (out, YEAR_W) and leap (out, 1: current year is leap).
REQ-009 SHALL have ports busy (out, 1: conversion in progress), tick (out, 1: prescaler pulse) and year_roll (out, 1: one-cycle pulse on year change by advance).

Function
REQ-010 SHALL compute leap = (year[1:0]==2'b00) | leap_force, combinationally, with year_len = leap ? 366 : 365 and Feb length = leap ? 29 : 28.
REQ-011 SHALL use a two-state FSM, RUN and CONV.
REQ-012 SHALL, in RUN with run_en=1, count a prescaler 0..DIV-1; tick pulses for one cycle on the wrap from DIV-1 to 0.
REQ-013 SHALL hold the prescaler when run_en=0 and clear it in CONV.
REQ-014 SHALL define the advance event in RUN as tick | step; a simultaneous tick and step SHALL produce a single advance.
REQ-015 SHALL, on a forward advance, increment doy and day; day==month_len SHALL give day=1, month+1.
REQ-016 SHALL, on a forward advance with doy>=year_len, give doy=1, month=1, day=1, year+1 (mod 2^YEAR_W) and pulse year_roll.
REQ-017 SHALL, on a backward advance, decrement doy and day; day==1 SHALL give month-1 and day=length of the new month.
REQ-018 SHALL, on a backward advance with doy==1, give year-1, month=12, day=31 and doy=year_len of the new year, and pulse year_roll.
REQ-019 SHALL make advances single-cycle; outputs update on the edge following the advance event.
REQ-020 SHALL, on a load accepted in either state, register year=load_year, clamp doy to 1 if load_doy==0 and to year_len (evaluated with the new year) if load_doy>year_len, and enter CONV.
REQ-021 SHALL, in CONV, hold busy=1 and hold internal iterators m (init 1) and r (init doy).
REQ-022 SHALL, on each CONV cycle with r>len(m), set r-=len(m) and m+=1; otherwise it SHALL write month=m and day=r and return to RUN.
REQ-023 SHALL keep busy high for exactly the target month index cycles (1..12).
REQ-024 SHALL hold month and day at their previous values during CONV.
REQ-025 SHALL ignore step and advances during CONV; a load during CONV SHALL restart the conversion.
REQ-026 SHALL give load priority over a same-cycle step or tick.
REQ-027 SHALL treat doy>year_len after leap_force deasserts (doy=366) as the last day; the next forward advance wraps the year.

Reset
REQ-028 SHALL, on rst_n low, asynchronously set month=1, day=1, doy=1, year=YEAR_INIT, prescaler=0, tick=0, year_roll=0, busy=0 and state=RUN.
REQ-029 SHALL fully abort a conversion in progress on reset.
REQ-030 SHALL resume counting on the first rising edge after rst_n is released.

Verification
REQ-031 SHALL verify: load doy=60, year=2001 -> busy for 3 cycles, then month=3, day=1; load doy=60, year=2000 -> busy for 2 cycles, then 2/29.
REQ-032 SHALL verify: year=2023, doy=365, step with dir=0 -> doy=1, 1/1, year=2024, year_roll high for 1 cycle.
REQ-033 SHALL verify: year=2024, doy=1, step with dir=1 -> year=2023, doy=365, 12/31, year_roll pulse.
REQ-034 SHALL verify, with DIV=4 and run_en=1 from 1/1: tick every 4th cycle; after 31 ticks month=2, day=1, doy=32; dropping run_en freezes the prescaler.
REQ-035 SHALL verify: load doy=0 -> 1/1; load doy=400 with year=2023 -> doy=365, busy for 12 cycles, then 12/31; a step during busy leaves the result unchanged.
REQ-036 SHALL verify: rst_n pulsed low mid-CONV -> immediate reset values, busy=0; leap_force=1 with year=2023 and doy=366 -> 12/31.
